// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU boot sequencer: FSM state encoding and instruction memory geometry.
package cpu_pkg;

  localparam int unsigned IMEM_ADDR_W = 15;
  localparam int unsigned IMEM_WORDS  = 32768;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_CSUM  = 3'd3,
    ST_RUN   = 3'd4,
    ST_HALT  = 3'd5,
    ST_ERROR = 3'd6
  } boot_state_e;

endpackage

// File: rtl/cpu_boot_ctrl_if.sv
// Loader byte stream and instruction-RAM write port of the boot sequencer.
interface cpu_boot_ctrl_if
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = IMEM_ADDR_W
);

  logic [7:0]        in_byte;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;

  modport master (
    output in_byte,
    output in_valid,
    input  in_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

  modport slave (
    input  in_byte,
    input  in_valid,
    output in_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

endinterface

// File: rtl/boot_word_asm.sv
// Pairs accepted bytes (HI first, then LO) into 16-bit words; word_valid_o pulses one cycle
// after the LO byte is accepted.
module boot_word_asm (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  output logic        word_valid_o,
  output logic [15:0] word_o
);

  logic        hi_seen_q;
  logic [7:0]  hi_q;
  logic        word_valid_q;
  logic [15:0] word_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      hi_seen_q    <= 1'b0;
      hi_q         <= 8'h00;
      word_valid_q <= 1'b0;
      word_q       <= 16'h0000;
    end else begin
      word_valid_q <= 1'b0;
      if (byte_valid_i) begin
        if (hi_seen_q) begin
          word_q       <= {hi_q, byte_i};
          word_valid_q <= 1'b1;
          hi_seen_q    <= 1'b0;
        end else begin
          hi_q      <= byte_i;
          hi_seen_q <= 1'b1;
        end
      end
    end
  end

  assign word_valid_o = word_valid_q;
  assign word_o       = word_q;

endmodule

// File: rtl/cpu_boot_ctrl.sv
// Boot/run sequencer: loads a length-prefixed program into instruction RAM, then runs the CPU
// with halt/step/resume control. Define BOOT_CHECKSUM_EN to require a trailing 16-bit checksum.
module cpu_boot_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W    = IMEM_ADDR_W,
  parameter int unsigned MAX_WORDS = IMEM_WORDS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  cpu_boot_ctrl_if.slave        bus,
  output logic                  cpu_rst,
  output logic                  cpu_clk_en,
  input  logic                  halt,
  input  logic                  step,
  input  logic                  resume,
  output logic [2:0]            state_o,
  output logic                  err
);

  localparam logic [16:0] MaxWordsL = 17'(MAX_WORDS);

  boot_state_e state_q;
  logic [15:0] len_q, cnt_q, csum_q;
  logic        cpu_rst_q, clk_en_q, err_q;
  logic        byte_acc, load_go, word_valid;
  logic [15:0] word;

  assign bus.in_ready = (state_q == ST_HDR) || (state_q == ST_LOAD) || (state_q == ST_CSUM);
  assign byte_acc     = bus.in_valid && bus.in_ready;
  assign load_go      = load_start && (state_q inside {ST_IDLE, ST_RUN, ST_HALT, ST_ERROR});

  boot_word_asm u_word_asm (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (load_go),
    .byte_i       (bus.in_byte),
    .byte_valid_i (byte_acc),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      len_q     <= 16'h0000;
      cnt_q     <= 16'h0000;
      csum_q    <= 16'h0000;
      cpu_rst_q <= 1'b1;
      clk_en_q  <= 1'b0;
      err_q     <= 1'b0;
    end else if (load_go) begin
      // A reload freezes and resets the CPU on this very edge, not a cycle later.
      state_q   <= ST_HDR;
      cnt_q     <= 16'h0000;
      csum_q    <= 16'h0000;
      cpu_rst_q <= 1'b1;
      clk_en_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      cpu_rst_q <= !((state_q == ST_RUN) || (state_q == ST_HALT));
      clk_en_q  <= (state_q == ST_RUN) || ((state_q == ST_HALT) && step && !resume);
      unique case (state_q)
        ST_HDR: begin
          if (word_valid) begin
            if ((word == 16'h0000) || ({1'b0, word} > MaxWordsL)) begin
              state_q <= ST_ERROR;
              err_q   <= 1'b1;
            end else begin
              len_q   <= word;
              cnt_q   <= 16'h0000;
              csum_q  <= 16'h0000;
              state_q <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (word_valid) begin
            cnt_q  <= cnt_q + 16'd1;
            csum_q <= csum_q + word;
            if (cnt_q + 16'd1 == len_q) begin
`ifdef BOOT_CHECKSUM_EN
              state_q <= ST_CSUM;
`else
              state_q <= ST_RUN;
`endif
            end
          end
        end
        ST_CSUM: begin
`ifdef BOOT_CHECKSUM_EN
          if (word_valid) begin
            if (word == csum_q) begin
              state_q <= ST_RUN;
            end else begin
              state_q <= ST_ERROR;
              err_q   <= 1'b1;
            end
          end
`else
          state_q <= ST_IDLE;
`endif
        end
        ST_RUN:  if (halt) state_q <= ST_HALT;
        ST_HALT: if (resume) state_q <= ST_RUN;
        default: ;
      endcase
    end
  end

  assign bus.imem_we    = word_valid && (state_q == ST_LOAD);
  assign bus.imem_addr  = cnt_q[ADDR_W-1:0];
  assign bus.imem_wdata = word;
  assign cpu_rst        = cpu_rst_q;
  assign cpu_clk_en     = clk_en_q;
  assign state_o        = state_q;
  assign err            = err_q;

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// Randomized self-checking bench for cpu_boot_ctrl against a stream-level load model.
module tb_cpu_boot_ctrl;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst, load_start, halt, step, resume;
  logic       cpu_rst, cpu_clk_en, err;
  logic [2:0] state_o;

  cpu_boot_ctrl_if bus ();

  cpu_boot_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .bus        (bus),
    .cpu_rst    (cpu_rst),
    .cpu_clk_en (cpu_clk_en),
    .halt       (halt),
    .step       (step),
    .resume     (resume),
    .state_o    (state_o),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0]  stream_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  boot_state_e exp_state;
  logic        exp_err;

  always @(negedge clk) if (bus.imem_we) got_q.push_back({1'b0, bus.imem_addr, bus.imem_wdata});

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected writes and end state derived directly from the stream format.
  task automatic model();
    int          n;
    logic [15:0] sum, w;
    exp_q.delete();
    n = int'({stream_q[0], stream_q[1]});
    if (n == 0 || n > 32768) begin
      exp_state = ST_ERROR;
      exp_err   = 1'b1;
      return;
    end
    sum = 16'h0000;
    for (int i = 0; i < n; i++) begin
      w   = {stream_q[2 + 2 * i], stream_q[3 + 2 * i]};
      sum = sum + w;
      exp_q.push_back({1'b0, 15'(i), w});
    end
    exp_state = ST_RUN;
`ifdef BOOT_CHECKSUM_EN
    if ({stream_q[2 + 2 * n], stream_q[3 + 2 * n]} != sum) exp_state = ST_ERROR;
`endif
    exp_err = (exp_state == ST_ERROR);
  endtask

  task automatic add_csum(input bit good);
`ifdef BOOT_CHECKSUM_EN
    logic [15:0] s;
    s = 16'h0000;
    for (int i = 2; i + 1 < stream_q.size(); i += 2) s = s + {stream_q[i], stream_q[i + 1]};
    if (!good) s = s + 16'($urandom_range(1, 65535));
    stream_q.push_back(s[15:8]);
    stream_q.push_back(s[7:0]);
`else
    if (good) return;
`endif
  endtask

  task automatic make_prog(input int n, input bit good);
    logic [15:0] nn, w;
    nn = 16'(n);
    stream_q.delete();
    stream_q.push_back(nn[15:8]);
    stream_q.push_back(nn[7:0]);
    for (int i = 0; i < n; i++) begin
      w = 16'($urandom);
      stream_q.push_back(w[15:8]);
      stream_q.push_back(w[7:0]);
    end
    add_csum(good);
  endtask

  // Gap cycles may carry a load_start pulse, which the loader states must ignore.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int g;
    if (gaps) begin
      g = $urandom_range(0, 2);
      repeat (g) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        load_start   = ($urandom_range(0, 3) == 0);
      end
    end
    @(negedge clk);
    load_start   = 1'b0;
    bus.in_byte  = b;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 200 && !bus.in_ready; t++) @(negedge clk);
    if (!bus.in_ready) check_eq("ready_timeout", 32'(bus.in_ready), 1);
    else @(posedge clk);
  endtask

  task automatic start_load();
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    check_eq("ld_enter", 32'(state_o), 32'(ST_HDR));
    check_eq("ld_err_clr", 32'(err), 0);
  endtask

  task automatic run_load(input bit gaps, input bit do_start);
    int t;
    got_q.delete();
    model();
    if (do_start) start_load();
    foreach (stream_q[i]) send_byte(stream_q[i], gaps);
    @(negedge clk);
    bus.in_valid = 1'b0;
    t = 0;
    while (state_o != exp_state && t < 50) begin
      @(negedge clk);
      t++;
    end
    check_eq("end_state", 32'(state_o), 32'(exp_state));
    check_eq("end_err", 32'(err), 32'(exp_err));
    check_eq("rst_lag", 32'(cpu_rst), 1);
    @(negedge clk);
    check_eq("cpu_rst", 32'(cpu_rst), 32'(exp_state == ST_ERROR));
    check_eq("clk_en", 32'(cpu_clk_en), 32'(exp_state == ST_RUN));
    check_eq("wr_cnt", 32'(got_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) if (i < got_q.size()) check_eq("wr", got_q[i], exp_q[i]);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_state", 32'(state_o), 32'(ST_IDLE));
    check_eq("rst_cpu_rst", 32'(cpu_rst), 1);
    check_eq("rst_clk_en", 32'(cpu_clk_en), 0);
    check_eq("rst_ready", 32'(bus.in_ready), 0);
    check_eq("rst_err", 32'(err), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, rises;
    logic prev;
    rst = 1'b1; load_start = 1'b0; halt = 1'b0; step = 1'b0; resume = 1'b0;
    bus.in_byte = 8'h00; bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("r_state", 32'(state_o), 32'(ST_IDLE));
    check_eq("r_cpu_rst", 32'(cpu_rst), 1);
    check_eq("r_clk_en", 32'(cpu_clk_en), 0);
    check_eq("r_ready", 32'(bus.in_ready), 0);
    check_eq("r_we", 32'(bus.imem_we), 0);
    check_eq("r_addr", 32'(bus.imem_addr), 0);
    check_eq("r_wdata", 32'(bus.imem_wdata), 0);
    check_eq("r_err", 32'(err), 0);
    rst = 1'b0;

    // Three-word program, streamed back to back.
    stream_q = '{8'h00, 8'h03, 8'h00, 8'h05, 8'hE3, 8'h08, 8'hEA, 8'h87};
    add_csum(1'b1);
    run_load(1'b0, 1'b1);

    // Halt (with a simultaneous resume, halt wins), three steps, then step+resume.
    @(negedge clk); halt = 1'b1; resume = 1'b1;
    @(negedge clk); halt = 1'b0; resume = 1'b0;
    @(negedge clk);
    check_eq("halt_state", 32'(state_o), 32'(ST_HALT));
    check_eq("halt_frozen", 32'(cpu_clk_en), 0);
    hi = 0; rises = 0; prev = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step = 1'b1;
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        step = 1'b0;
        hi += int'(cpu_clk_en);
        if (cpu_clk_en && !prev) rises++;
        prev = cpu_clk_en;
      end
    end
    check_eq("step_hi", 32'(hi), 3);
    check_eq("step_rises", 32'(rises), 3);
    check_eq("step_state", 32'(state_o), 32'(ST_HALT));
    step = 1'b1; resume = 1'b1;
    @(negedge clk); step = 1'b0; resume = 1'b0;
    check_eq("sr_no_pulse", 32'(cpu_clk_en), 0);
    check_eq("sr_state", 32'(state_o), 32'(ST_RUN));
    hi = 0;
    repeat (6) begin
      @(negedge clk);
      hi += int'(cpu_clk_en);
    end
    check_eq("resume_run", 32'(hi), 6);

    // load_start beats a simultaneous halt while running.
    @(negedge clk); load_start = 1'b1; halt = 1'b1;
    @(negedge clk); load_start = 1'b0; halt = 1'b0;
    check_eq("ls_state", 32'(state_o), 32'(ST_HDR));
    check_eq("ls_cpu_rst", 32'(cpu_rst), 1);
    check_eq("ls_clk_en", 32'(cpu_clk_en), 0);
    make_prog(2, 1'b1);
    run_load(1'b1, 1'b0);

    // Illegal headers, then the largest legal length.
    stream_q = '{8'h00, 8'h00};
    run_load(1'b0, 1'b1);
    stream_q = '{8'h80, 8'h01};
    run_load(1'b0, 1'b1);
    start_load();
    send_byte(8'h80, 1'b0);
    send_byte(8'h00, 1'b0);
    @(negedge clk); bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("max_len_load", 32'(state_o), 32'(ST_LOAD));
    check_eq("max_len_err", 32'(err), 0);
    pulse_rst();

    // Reset in the middle of a four-word load, then a fresh one-word load.
    got_q.delete();
    start_load();
    stream_q = '{8'h00, 8'h04, 8'h12, 8'h34, 8'h56, 8'h78};
    foreach (stream_q[i]) send_byte(stream_q[i], 1'b0);
    @(negedge clk); bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("partial_wr", 32'(got_q.size()), 2);
    pulse_rst();
    make_prog(1, 1'b1);
    run_load(1'b1, 1'b1);

`ifdef BOOT_CHECKSUM_EN
    stream_q = '{8'h00, 8'h03, 8'h00, 8'h05, 8'hE3, 8'h08, 8'hEA, 8'h87, 8'hCD, 8'h94};
    run_load(1'b0, 1'b1);
    stream_q = '{8'h00, 8'h03, 8'h00, 8'h05, 8'hE3, 8'h08, 8'hEA, 8'h87, 8'h00, 8'h00};
    run_load(1'b0, 1'b1);
`endif

    for (int r = 0; r < 10; r++) begin
      if ($urandom_range(0, 4) == 0) begin
        make_prog(0, 1'b1);
        if ($urandom_range(0, 1) == 1) begin
          stream_q.delete();
          stream_q.push_back(8'h80 | 8'($urandom_range(0, 127)));
          stream_q.push_back(8'h01 | 8'($urandom));
        end else begin
          stream_q = '{8'h00, 8'h00};
        end
      end else begin
        make_prog($urandom_range(1, 7), ($urandom_range(0, 3) != 0));
      end
      run_load(1'b1, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
